// File: rtl/pwm_ramp_ctrl.sv
// Purpose: PWM generator whose duty slews one step at a time toward a requested target.
// Latency: ack one cycle after req; duty only moves at a period boundary; pwm lags duty compare by one cycle.
// Backpressure: none; req is always accepted and a new target simply replaces the old one.
//
// Ports:
//   clk, rst_n    - single clock, asynchronous active-low reset
//   target, req   - requested duty, latched on any cycle req is high
//   rate          - one ramp step every rate+1 PWM periods (sampled live at each boundary)
//   ack           - one-cycle pulse following every accepted req
//   duty, pwm     - duty currently applied and the registered PWM waveform
//   period_start  - one-cycle pulse in the first cycle (cnt==0) of each period
//   busy, done    - busy while ramping; done pulses when duty reaches the target
//
// Build option: define PWM_RAMP_EN to slew duty gradually. Without it duty jumps
// straight to the target at the next period boundary and rate is ignored.
module pwm_ramp_ctrl #(
  parameter int BITS   = 4,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   target,
  input  logic              req,
  input  logic [RATE_W-1:0] rate,
  output logic              ack,
  output logic [BITS-1:0]   duty,
  output logic              pwm,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [BITS-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] tgt_q, tgt_d;
  logic [BITS-1:0] duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic            ack_q, ack_d;
  logic            period_start_q, period_start_d;
  logic            done_q, done_d;
  logic            boundary;

`ifdef PWM_RAMP_EN
  logic [RATE_W-1:0] pre_q, pre_d;
  logic [BITS-1:0]   step_val;
`else
  logic unused_rate;
  assign unused_rate = ^rate;
`endif

  // Free-running period counter and the signals that follow it directly.
  always_comb begin
    boundary       = (cnt_q == CNT_MAX);
    cnt_d          = cnt_q + BITS'(1);
    pwm_d          = (cnt_q < duty_q);
    period_start_d = boundary;
    ack_d          = req;
    tgt_d          = req ? target : tgt_q;
  end

  // Ramp FSM. Any step taken on an edge where req also fires uses the old tgt_q;
  // the newly latched target takes over from the following cycle.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
`ifdef PWM_RAMP_EN
    pre_d    = pre_q;
    step_val = (tgt_q > duty_q) ? duty_q + BITS'(1) : duty_q - BITS'(1);
`endif
    case (state_q)
      IDLE: begin
        if (tgt_q != duty_q) begin
          state_d = RAMP;
`ifdef PWM_RAMP_EN
          pre_d   = '0;
`endif
        end
      end
      RAMP: begin
        if (tgt_q == duty_q) begin
          // Target was re-requested at the current duty: nothing left to do,
          // and no completion is signalled because duty never moved to get here.
          state_d = IDLE;
        end else if (boundary) begin
`ifdef PWM_RAMP_EN
          if (pre_q == rate) begin
            // Single step toward tgt_q; since duty != tgt it cannot pass or wrap.
            duty_d = step_val;
            pre_d  = '0;
            if (step_val == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            // A direction reversal keeps the prescaler running on purpose.
            pre_d = pre_q + RATE_W'(1);
          end
`else
          duty_d  = tgt_q;
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tgt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      ack_q          <= 1'b0;
      period_start_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef PWM_RAMP_EN
      pre_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tgt_q          <= tgt_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      ack_q          <= ack_d;
      period_start_q <= period_start_d;
      done_q         <= done_d;
`ifdef PWM_RAMP_EN
      pre_q          <= pre_d;
`endif
    end
  end

  assign ack          = ack_q;
  assign duty         = duty_q;
  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign busy         = (state_q == RAMP);
  assign done         = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Purpose: self-checking bench for pwm_ramp_ctrl (ramping or direct-load build).
// Latency: expected duty steps queued at stimulus time, popped as duty changes.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_pwm_ramp_ctrl;

  localparam int BITS   = 4;
  localparam int RATE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BITS-1:0]   target = '0;
  logic              req = 1'b0;
  logic [RATE_W-1:0] rate = '0;
  logic              ack;
  logic [BITS-1:0]   duty;
  logic              pwm;
  logic              period_start;
  logic              busy;
  logic              done;

  pwm_ramp_ctrl #(.BITS(BITS), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .target(target), .req(req), .rate(rate),
    .ack(ack), .duty(duty), .pwm(pwm), .period_start(period_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] duty;
    int              gap;   // periods since previous duty change, 0 = don't care
  } exp_t;

  exp_t            sb_q[$];
  exp_t            mon_e;
  int              vectors = 0;
  int              miscompares = 0;
  int              done_seen = 0;
  int              periods_since = 0;
  logic [BITS-1:0] prev_duty = '0;

  // Scoreboard consumer: every duty change must sit on a period start and match
  // the next queued expectation, including the spacing between steps.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_duty     = '0;
      periods_since = 0;
    end else begin
      if (done === 1'b1) done_seen++;
      if (period_start === 1'b1) periods_since++;
      if (duty !== prev_duty) begin
        vectors++;
        if (period_start !== 1'b1) begin
          miscompares++;
          $display("FAIL duty_at_boundary: duty changed to %0d with period_start=%b, required 1", duty, period_start);
        end
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL duty_seq: duty changed to %0d, required no change", duty);
        end else begin
          mon_e = sb_q.pop_front();
          if (duty !== mon_e.duty) begin
            miscompares++;
            $display("FAIL duty_seq: duty=%0d, required %0d", duty, mon_e.duty);
          end
          if (mon_e.gap != 0) begin
            vectors++;
            if (periods_since != mon_e.gap) begin
              miscompares++;
              $display("FAIL step_gap: %0d periods between steps, required %0d", periods_since, mon_e.gap);
            end
          end
        end
        prev_duty     = duty;
        periods_since = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [BITS-1:0] d, input int g);
    exp_t e;
    e.duty = d;
    e.gap  = g;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    vectors++;
    if ({ack, duty, pwm, period_start, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b duty=%0d pwm=%b ps=%b busy=%b done=%b, required all 0",
               ack, duty, pwm, period_start, busy, done);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int last_ps  = -1;
    int ps_count = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (pwm !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_pwm_busy: pwm=%b busy=%b, required 0 0", pwm, busy);
      end
      if (period_start === 1'b1) begin
        if (last_ps >= 0) begin
          vectors++;
          if (i - last_ps != 16) begin
            miscompares++;
            $display("FAIL idle_period: period_start spacing %0d, required 16", i - last_ps);
          end
        end
        last_ps = i;
        ps_count++;
      end
    end
    vectors++;
    if (ps_count < 2) begin
      miscompares++;
      $display("FAIL idle_ps_count: %0d pulses in 40 cycles, required at least 2", ps_count);
    end
  endtask

  task automatic test_ramp_up();
    int d0 = done_seen;
    int n  = 0;
    int hi = 0;
`ifdef PWM_RAMP_EN
    push_exp(4'd1, 0); push_exp(4'd2, 1); push_exp(4'd3, 1); push_exp(4'd4, 1);
`else
    push_exp(4'd4, 0);
`endif
    target = 4'd4; rate = 8'd0; req = 1'b1;
    tick();
    req = 1'b0;
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL up_ack: ack=%b, required 1", ack); end
    tick();
    vectors++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL up_ack_busy: ack=%b busy=%b, required 0 1", ack, busy);
    end
    while (!(duty === 4'd4 && busy === 1'b0) && n < 200) begin tick(); n++; end
    tick();
    vectors++;
    if (duty !== 4'd4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL up_final: duty=%0d busy=%b, required 4 0", duty, busy);
    end
    vectors++;
    if (done_seen - d0 != 1) begin miscompares++; $display("FAIL up_done: %0d done pulses, required 1", done_seen - d0); end
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL up_queue: %0d steps missing, required 0", sb_q.size()); end
    for (int i = 0; i < 16; i++) begin tick(); if (pwm === 1'b1) hi++; end
    vectors++;
    if (hi != 4) begin miscompares++; $display("FAIL up_pwm_high: pwm high %0d of 16, required 4", hi); end
  endtask

  task automatic test_ramp_down();
    int d0 = done_seen;
    int n  = 0;
`ifdef PWM_RAMP_EN
    push_exp(4'd3, 0); push_exp(4'd2, 3); push_exp(4'd1, 3);
`else
    push_exp(4'd1, 0);
`endif
    target = 4'd1; rate = 8'd2; req = 1'b1;
    tick();
    req = 1'b0;
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL down_ack: ack=%b, required 1", ack); end
    while (n < 300) begin
      tick();
      n++;
      if (duty === 4'd1) break;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL down_busy: busy=%b at duty=%0d, required 1", busy, duty); end
    end
    tick();
    vectors++;
    if (duty !== 4'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL down_final: duty=%0d busy=%b, required 1 0", duty, busy);
    end
    vectors++;
    if (done_seen - d0 != 1) begin miscompares++; $display("FAIL down_done: %0d done pulses, required 1", done_seen - d0); end
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL down_queue: %0d steps missing, required 0", sb_q.size()); end
  endtask

`ifdef PWM_RAMP_EN
  task automatic test_reverse();
    int d0 = done_seen;
    int n  = 0;
    push_exp(4'd2, 0);
    for (int v = 3; v <= 6; v++) push_exp(4'(v), 1);
    target = 4'd10; rate = 8'd0; req = 1'b1;
    tick();
    req = 1'b0;
    while (duty !== 4'd6 && n < 200) begin tick(); n++; end
    push_exp(4'd5, 1); push_exp(4'd4, 1); push_exp(4'd3, 1);
    target = 4'd3; req = 1'b1;
    tick();
    req = 1'b0;
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL rev_ack: ack=%b, required 1", ack); end
    n = 0;
    while (!(duty === 4'd3 && busy === 1'b0) && n < 200) begin tick(); n++; end
    tick();
    vectors++;
    if (duty !== 4'd3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rev_final: duty=%0d busy=%b, required 3 0", duty, busy);
    end
    vectors++;
    if (done_seen - d0 != 1) begin miscompares++; $display("FAIL rev_done: %0d done pulses, required 1", done_seen - d0); end
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL rev_queue: %0d steps missing, required 0", sb_q.size()); end
  endtask
`endif

  task automatic test_reset_mid_ramp(input logic [BITS-1:0] start);
    int n = 0;
`ifdef PWM_RAMP_EN
    push_exp(start + 4'd1, 0);
    for (int v = int'(start) + 2; v <= 12; v++) push_exp(4'(v), 1);
`else
    push_exp(4'd12, 0);
`endif
    target = 4'd12; rate = 8'd0; req = 1'b1;
    tick();
    req = 1'b0;
    while (busy !== 1'b1 && n < 20) begin tick(); n++; end
`ifdef PWM_RAMP_EN
    n = 0;
    while (duty !== start + 4'd2 && n < 100) begin tick(); n++; end
    repeat (5) tick();
`endif
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: busy=%b before reset, required 1", busy); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, duty, pwm, period_start, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ack=%b duty=%0d pwm=%b ps=%b busy=%b done=%b, required all 0",
               ack, duty, pwm, period_start, busy, done);
    end
    sb_q.delete();
    #20;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (ack !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || duty !== 4'd0) begin
        miscompares++;
        $display("FAIL post_reset: ack=%b done=%b busy=%b duty=%0d, required 0 0 0 0", ack, done, busy, duty);
      end
    end
  endtask

`ifndef PWM_RAMP_EN
  task automatic test_direct();
    int d0 = done_seen;
    int n  = 0;
    push_exp(4'd9, 0);
    target = 4'd9; rate = 8'd0; req = 1'b1;
    tick();
    req = 1'b0;
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL direct_ack: ack=%b, required 1", ack); end
    while (duty !== 4'd9 && n < 40) begin tick(); n++; end
    vectors++;
    if (n > 17) begin miscompares++; $display("FAIL direct_latency: %0d cycles to load, required at most 17", n); end
    tick();
    vectors++;
    if (duty !== 4'd9 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_final: duty=%0d busy=%b, required 9 0", duty, busy);
    end
    vectors++;
    if (done_seen - d0 != 1) begin miscompares++; $display("FAIL direct_done: %0d done pulses, required 1", done_seen - d0); end
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL direct_queue: %0d steps missing, required 0", sb_q.size()); end
  endtask
`endif

  // req held high for several cycles at the current duty: ack every cycle, no ramp, no done.
  task automatic test_back_to_back(input logic [BITS-1:0] cur);
    int d0 = done_seen;
    target = cur; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack: ack=%b in held cycle %0d, required 1", ack, i); end
    end
    req = 1'b0;
    tick();
    vectors++;
    if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_end: ack=%b, required 0", ack); end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || duty !== cur) begin
        miscompares++;
        $display("FAIL b2b_stable: busy=%b duty=%0d, required 0 %0d", busy, duty, cur);
      end
    end
    vectors++;
    if (done_seen - d0 != 0) begin miscompares++; $display("FAIL b2b_done: %0d done pulses, required 0", done_seen - d0); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ramp_up();
    test_ramp_down();
`ifdef PWM_RAMP_EN
    test_reverse();
    test_reset_mid_ramp(4'd3);
    test_back_to_back(4'd0);
`else
    test_reset_mid_ramp(4'd1);
    test_direct();
    test_back_to_back(4'd9);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
